bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter RAM_LATENCY, default 1: wait cycles for cpu_ram and cop_ram reads and writes.
REQ-002 Parameter PERIPH_LATENCY, default 2: wait cycles for status, dsp and pad accesses.
REQ-003 Parameter TIMEOUT, default 255: maximum WAIT cycles for handshake targets (vdp, flash) before an error response.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 cpu_mem_valid  in  1  CPU request strobe; held high until cpu_mem_ready.
REQ-007 cpu_wstrb  in  4  byte write strobes; nonzero means write.
REQ-008 cpu_ram_en, vdp_en, status_en, dsp_en, pad_en, cop_ram_en, flash_read_en  in  1 each  target selects from the address decoder.
REQ-009 cpu_ram_rdata, vdp_rdata, status_rdata, dsp_rdata, pad_rdata, flash_rdata  in  32 each  target read data.
REQ-010 vdp_ready, flash_ready  in  1 each  target completion strobes.
REQ-011 error_clear  in  1  clears bus_error.
REQ-012 cpu_mem_ready  out  1  one-cycle completion pulse to the CPU.
REQ-013 cpu_mem_rdata  out  32  response data, valid while cpu_mem_ready is high.
REQ-014 bus_error  out  1  sticky error flag.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, WAIT, RESPOND.
REQ-017 IDLE with cpu_mem_valid high and exactly one select high: latch the target index and write flag, load the latency counter, go to WAIT.
REQ-018 IDLE with cpu_mem_valid high and zero or more than one select high: set bus_error, load response data 0xFFFF_FFFF, go directly to RESPOND.
REQ-019 Fixed-latency targets (cpu_ram, cop_ram, status, dsp, pad): for an access accepted in cycle N, WAIT spans cycles N+1 to N+LAT, and RESPOND (cpu_mem_ready=1) occurs in cycle N+LAT+1.
REQ-020 At the last WAIT cycle, sample the selected target's rdata into the response register.
REQ-021 Handshake targets (vdp, flash): remain in WAIT until the matching ready input is high; on ready in cycle M, latch rdata in cycle M and RESPOND in cycle M+1.
REQ-022 Handshake timeout: count WAIT cycles; if the count reaches TIMEOUT without ready, set bus_error, respond with 0xFFFF_FFFF, go to RESPOND.
REQ-023 Ready arriving in the same cycle the count reaches TIMEOUT: ready wins, no error.
REQ-024 cop_ram is write-only; a read of cop_ram returns 0x0000_0000.
REQ-025 Writes (cpu_wstrb != 0) return cpu_mem_rdata = 0.
REQ-026 RESPOND lasts exactly one cycle, then IDLE; a new request is accepted no earlier than the IDLE cycle that follows.
REQ-027 cpu_mem_rdata is 0 whenever cpu_mem_ready is low.
REQ-028 cpu_mem_valid dropping during WAIT: abort to IDLE, no cpu_mem_ready pulse, bus_error unchanged.
REQ-029 bus_error is set by REQ-018 or REQ-022 and cleared only by error_clear or reset; set wins over a simultaneous error_clear.
REQ-030 Selects and cpu_wstrb are sampled only in IDLE; later changes have no effect on the transaction in progress.

Reset
REQ-031 Reset drives the FSM to IDLE and clears cpu_mem_ready, cpu_mem_rdata, bus_error, busy, all counters and the latched target, asynchronously.
REQ-032 Reset asserted mid-transaction discards that transaction; no cpu_mem_ready pulse is issued after reset is released.

Structure
REQ-033 Target index encoding, the error data pattern 0xFFFF_FFFF and the default latencies are defined in a shared include, bus_defs.vh, which the address decoder also uses.
REQ-034 The handshake timeout counter is a sub-module, bus_timeout_counter (load, enable, expired).

Verification
REQ-035 cpu_ram read, RAM_LATENCY=1, cpu_ram_rdata=0x12345678, valid accepted in cycle 10 -> cpu_mem_ready only in cycle 12 with rdata 0x12345678.
REQ-036 pad write, wstrb=0xF -> cpu_mem_ready in cycle N+3, cpu_mem_rdata=0, bus_error=0.
REQ-037 flash read, flash_ready asserted 40 cycles after accept, flash_rdata=0xCAFEF00D -> ready one cycle after flash_ready, correct data, no error.
REQ-038 vdp read, vdp_ready held low -> after 255 WAIT cycles, cpu_mem_ready with 0xFFFF_FFFF and bus_error=1; error_clear pulse -> bus_error=0.
REQ-039 valid with status_en and dsp_en both high -> cpu_mem_ready in cycle N+1, 0xFFFF_FFFF, bus_error=1.
REQ-040 Reset asserted during WAIT of a dsp read -> outputs are zero immediately, FSM is in IDLE, and no ready pulse follows.

Source files
------------

// File: rtl/bus_responder_pkg.sv
// rtl/bus_responder_pkg.sv - shared target encoding, error pattern and default latencies
package bus_responder_pkg;

  localparam int NUM_TARGETS = 7;

  // Bit positions of the select vector; the address decoder uses the same order.
  typedef enum logic [2:0] {
    TGT_CPU_RAM = 3'd0,
    TGT_VDP     = 3'd1,
    TGT_STATUS  = 3'd2,
    TGT_DSP     = 3'd3,
    TGT_PAD     = 3'd4,
    TGT_COP_RAM = 3'd5,
    TGT_FLASH   = 3'd6
  } target_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESPOND
  } state_e;

  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

  localparam int DEF_RAM_LATENCY    = 1;
  localparam int DEF_PERIPH_LATENCY = 2;
  localparam int DEF_TIMEOUT        = 255;

  function automatic logic is_handshake(input target_e t);
    return (t == TGT_VDP) || (t == TGT_FLASH);
  endfunction

  function automatic logic is_ram(input target_e t);
    return (t == TGT_CPU_RAM) || (t == TGT_COP_RAM);
  endfunction

  // Only meaningful for a one-hot select vector.
  function automatic target_e sel_index(input logic [NUM_TARGETS-1:0] sel);
    target_e idx;
    idx = TGT_CPU_RAM;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (sel[i]) idx = target_e'(i[2:0]);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_responder_timeout_counter.sv
// rtl/bus_responder_timeout_counter.sv - WAIT-cycle counter for handshake targets
module bus_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // expired marks the TIMEOUT-th WAIT cycle itself, so the caller can still let ready win.
  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - CPU bus responder: decodes a request, waits on the target, returns one ready pulse
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int RAM_LATENCY    = DEF_RAM_LATENCY,
  parameter int PERIPH_LATENCY = DEF_PERIPH_LATENCY,
  parameter int TIMEOUT        = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_valid,
  input  logic [3:0]  cpu_wstrb,
  input  logic        cpu_ram_en,
  input  logic        vdp_en,
  input  logic        status_en,
  input  logic        dsp_en,
  input  logic        pad_en,
  input  logic        cop_ram_en,
  input  logic        flash_read_en,
  input  logic [31:0] cpu_ram_rdata,
  input  logic [31:0] vdp_rdata,
  input  logic [31:0] status_rdata,
  input  logic [31:0] dsp_rdata,
  input  logic [31:0] pad_rdata,
  input  logic [31:0] flash_rdata,
  input  logic        vdp_ready,
  input  logic        flash_ready,
  input  logic        error_clear,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,
  output logic        bus_error,
  output logic        busy
);

  localparam int MAX_LAT = (RAM_LATENCY > PERIPH_LATENCY) ? RAM_LATENCY : PERIPH_LATENCY;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);

  logic [NUM_TARGETS-1:0] sel;
  assign sel = {flash_read_en, cop_ram_en, pad_en, dsp_en, status_en, vdp_en, cpu_ram_en};

  state_e            state_q, state_d;
  target_e           tgt_q, tgt_d;
  logic              wr_q, wr_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              err_set;
  logic              to_load;
  logic              to_en;
  logic              to_expired;
  logic              hs_ready;
  logic [31:0]       tgt_rdata;
  logic [31:0]       resp_data;

  bus_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (reset),
    .load   (to_load),
    .enable (to_en),
    .expired(to_expired)
  );

  // cop_ram has no read port, so it falls through to zero.
  always_comb begin
    tgt_rdata = '0;
    case (tgt_q)
      TGT_CPU_RAM: tgt_rdata = cpu_ram_rdata;
      TGT_VDP:     tgt_rdata = vdp_rdata;
      TGT_STATUS:  tgt_rdata = status_rdata;
      TGT_DSP:     tgt_rdata = dsp_rdata;
      TGT_PAD:     tgt_rdata = pad_rdata;
      TGT_FLASH:   tgt_rdata = flash_rdata;
      default:     tgt_rdata = '0;
    endcase
  end

  assign hs_ready  = ((tgt_q == TGT_VDP) && vdp_ready) || ((tgt_q == TGT_FLASH) && flash_ready);
  assign resp_data = wr_q ? '0 : tgt_rdata;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    wr_d    = wr_q;
    lat_d   = lat_q;
    ready_d = 1'b0;
    rdata_d = '0;
    err_set = 1'b0;
    to_load = 1'b0;
    to_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_mem_valid) begin
          to_load = 1'b1;
          if ($onehot(sel)) begin
            tgt_d   = sel_index(sel);
            wr_d    = |cpu_wstrb;
            lat_d   = is_ram(sel_index(sel)) ? LAT_W'(RAM_LATENCY) : LAT_W'(PERIPH_LATENCY);
            state_d = ST_WAIT;
          end else begin
            err_set = 1'b1;
            rdata_d = ERR_DATA;
            ready_d = 1'b1;
            state_d = ST_RESPOND;
          end
        end
      end
      ST_WAIT: begin
        if (!cpu_mem_valid) begin
          state_d = ST_IDLE;
        end else if (is_handshake(tgt_q)) begin
          if (hs_ready) begin
            rdata_d = resp_data;
            ready_d = 1'b1;
            state_d = ST_RESPOND;
          end else if (to_expired) begin
            err_set = 1'b1;
            rdata_d = ERR_DATA;
            ready_d = 1'b1;
            state_d = ST_RESPOND;
          end else begin
            to_en = 1'b1;
          end
        end else if (lat_q <= LAT_W'(1)) begin
          rdata_d = resp_data;
          ready_d = 1'b1;
          state_d = ST_RESPOND;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    err_d = err_set || (err_q && !error_clear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tgt_q   <= TGT_CPU_RAM;
      wr_q    <= 1'b0;
      lat_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      wr_q    <= wr_d;
      lat_q   <= lat_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cpu_mem_ready = ready_q;
  assign cpu_mem_rdata = rdata_q;
  assign bus_error     = err_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - self-checking bench for bus_responder
module tb_bus_responder;

  localparam int RAM_LAT = 1;
  localparam int PER_LAT = 2;
  localparam int TMO     = 255;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_mem_valid;
  logic [3:0]  cpu_wstrb;
  logic [6:0]  sel;
  logic [31:0] rd [7];
  logic        vdp_ready;
  logic        flash_ready;
  logic        error_clear;
  logic        cpu_mem_ready;
  logic [31:0] cpu_mem_rdata;
  logic        bus_error;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  logic err_model = 1'b0;

  bus_responder #(
    .RAM_LATENCY   (RAM_LAT),
    .PERIPH_LATENCY(PER_LAT),
    .TIMEOUT       (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_mem_valid(cpu_mem_valid),
    .cpu_wstrb    (cpu_wstrb),
    .cpu_ram_en   (sel[0]),
    .vdp_en       (sel[1]),
    .status_en    (sel[2]),
    .dsp_en       (sel[3]),
    .pad_en       (sel[4]),
    .cop_ram_en   (sel[5]),
    .flash_read_en(sel[6]),
    .cpu_ram_rdata(rd[0]),
    .vdp_rdata    (rd[1]),
    .status_rdata (rd[2]),
    .dsp_rdata    (rd[3]),
    .pad_rdata    (rd[4]),
    .flash_rdata  (rd[6]),
    .vdp_ready    (vdp_ready),
    .flash_ready  (flash_ready),
    .error_clear  (error_clear),
    .cpu_mem_ready(cpu_mem_ready),
    .cpu_mem_rdata(cpu_mem_rdata),
    .bus_error    (bus_error),
    .busy         (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Response latency counted in cycles after the accept cycle, from the rules for each target kind.
  function automatic void model(input logic [6:0] s, input logic [3:0] w, input int d,
                                output int lat, output logic [31:0] data, output logic err);
    int idx;
    idx = -1;
    for (int i = 0; i < 7; i++) if (s[i]) idx = i;
    if ($countones(s) != 1) begin
      lat  = 1;
      data = 32'hFFFF_FFFF;
      err  = 1'b1;
    end else begin
      err  = 1'b0;
      data = (w != 4'h0 || idx == 5) ? 32'h0 : rd[idx];
      if (idx == 1 || idx == 6) begin
        if (d >= 1 && d <= TMO) begin
          lat = d + 1;
        end else begin
          lat  = TMO + 1;
          data = 32'hFFFF_FFFF;
          err  = 1'b1;
        end
      end else begin
        lat = (idx == 0 || idx == 5) ? RAM_LAT + 1 : PER_LAT + 1;
      end
    end
  endfunction

  // d: cycle after accept in which the handshake target raises ready (0 = never).
  task automatic run_txn(input string tag, input logic [6:0] s, input logic [3:0] w,
                         input int d, input logic clr);
    int          exp_lat;
    logic [31:0] exp_data;
    logic        exp_err;
    int          hs;
    int          k;
    int          got_lat;
    logic [31:0] got_data;
    logic        got_err;
    logic        nz;
    model(s, w, d, exp_lat, exp_data, exp_err);
    hs = -1;
    if ($countones(s) == 1 && s[1]) hs = 1;
    if ($countones(s) == 1 && s[6]) hs = 6;
    sel           = s;
    cpu_wstrb     = w;
    cpu_mem_valid = 1'b1;
    error_clear   = clr;
    k        = 0;
    got_lat  = -1;
    got_data = '0;
    got_err  = 1'b0;
    nz       = 1'b0;
    while (got_lat < 0 && k < 400) begin
      step();
      k++;
      error_clear = 1'b0;
      if (k == 1) begin
        sel       = 7'($urandom);
        cpu_wstrb = 4'($urandom);
      end
      if (cpu_mem_ready) begin
        got_lat  = k;
        got_data = cpu_mem_rdata;
        got_err  = bus_error;
      end else if (cpu_mem_rdata !== 32'h0) begin
        nz = 1'b1;
      end
      vdp_ready   = (hs == 1) ? (k == d) : 1'($urandom);
      flash_ready = (hs == 6) ? (k == d) : 1'($urandom);
    end
    cpu_mem_valid = 1'b0;
    sel           = '0;
    cpu_wstrb     = '0;
    vdp_ready     = 1'b0;
    flash_ready   = 1'b0;
    err_model = (err_model && !clr) || exp_err;
    check({tag, " latency"}, 32'(got_lat), 32'(exp_lat));
    check({tag, " rdata"}, got_data, exp_data);
    check({tag, " bus_error"}, 32'(got_err), 32'(err_model));
    check({tag, " rdata_zero_while_not_ready"}, 32'(nz), 32'(0));
    step();
    check({tag, " ready_single_pulse"}, 32'(cpu_mem_ready), 32'(0));
    check({tag, " idle_after"}, 32'(busy), 32'(0));
  endtask

  task automatic clear_err();
    error_clear = 1'b1;
    step();
    error_clear = 1'b0;
    err_model   = 1'b0;
    check("error_clear", 32'(bus_error), 32'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        seen;
    logic [6:0]  s;
    logic [3:0]  w;
    int          d;
    reset         = 1'b1;
    cpu_mem_valid = 1'b0;
    cpu_wstrb     = '0;
    sel           = '0;
    vdp_ready     = 1'b0;
    flash_ready   = 1'b0;
    error_clear   = 1'b0;
    for (int i = 0; i < 7; i++) rd[i] = '0;
    #2;
    check("reset ready", 32'(cpu_mem_ready), 32'(0));
    check("reset rdata", cpu_mem_rdata, 32'h0);
    check("reset bus_error", 32'(bus_error), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    step();
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) rd[i] = $urandom;
    rd[0] = 32'h1234_5678;
    run_txn("cpu_ram_rd", 7'b0000001, 4'h0, 0, 1'b0);
    run_txn("pad_wr", 7'b0010000, 4'hF, 0, 1'b0);
    rd[6] = 32'hCAFE_F00D;
    run_txn("flash_rd", 7'b1000000, 4'h0, 40, 1'b0);
    run_txn("vdp_timeout", 7'b0000010, 4'h0, 0, 1'b0);
    clear_err();
    run_txn("vdp_ready_at_timeout", 7'b0000010, 4'h0, TMO, 1'b0);
    run_txn("flash_ready_too_late", 7'b1000000, 4'h0, TMO + 1, 1'b0);
    clear_err();
    run_txn("status_dsp_both", 7'b0001100, 4'h0, 0, 1'b0);
    clear_err();
    run_txn("no_sel_set_beats_clear", 7'b0000000, 4'h0, 0, 1'b1);
    run_txn("cop_ram_rd_sticky_err", 7'b0100000, 4'h0, 0, 1'b0);
    clear_err();
    run_txn("status_rd", 7'b0000100, 4'h0, 0, 1'b0);
    run_txn("vdp_wr", 7'b0000010, 4'h3, 7, 1'b0);

    sel           = 7'b0001000;
    cpu_mem_valid = 1'b1;
    step();
    check("abort busy_in_wait", 32'(busy), 32'(1));
    cpu_mem_valid = 1'b0;
    sel           = '0;
    seen          = 1'b0;
    repeat (4) begin
      step();
      if (cpu_mem_ready) seen = 1'b1;
    end
    check("abort no_ready", 32'(seen), 32'(0));
    check("abort idle", 32'(busy), 32'(0));
    check("abort bus_error", 32'(bus_error), 32'(err_model));

    run_txn("pre_reset_err", 7'b0000011, 4'h0, 0, 1'b0);
    rd[3]         = $urandom;
    sel           = 7'b0001000;
    cpu_mem_valid = 1'b1;
    step();
    reset = 1'b1;
    #1;
    check("mid_reset ready", 32'(cpu_mem_ready), 32'(0));
    check("mid_reset rdata", cpu_mem_rdata, 32'h0);
    check("mid_reset bus_error", 32'(bus_error), 32'(0));
    check("mid_reset busy", 32'(busy), 32'(0));
    err_model     = 1'b0;
    cpu_mem_valid = 1'b0;
    sel           = '0;
    step();
    step();
    reset = 1'b0;
    seen  = 1'b0;
    repeat (6) begin
      step();
      if (cpu_mem_ready) seen = 1'b1;
    end
    check("post_reset no_ready", 32'(seen), 32'(0));

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 7; i++) rd[i] = $urandom;
      if ($urandom_range(0, 9) == 0) s = 7'($urandom);
      else s = 7'(1 << $urandom_range(0, 6));
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 60));
      run_txn("random", s, w, d, 1'b0);
      if (err_model && $urandom_range(0, 1) == 1) clear_err();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
